// File: rtl/gene_pkg.sv
// Shared nucleotide types and helpers for the multi-pattern motif matcher.
// Window and pattern compares count mismatches through one popcount helper.
package gene_pkg;

    typedef logic [1:0] nucleotide_t;

    localparam nucleotide_t NT_A = 2'b00;
    localparam nucleotide_t NT_C = 2'b01;
    localparam nucleotide_t NT_G = 2'b10;
    localparam nucleotide_t NT_T = 2'b11;

    // Longest motif the mismatch counter can handle, and its result width.
    localparam int MAX_PAT_LEN = 64;
    localparam int POP_W       = 7;

    // A<->T and C<->G are bitwise inverses under this encoding.
    function automatic nucleotide_t complement(input nucleotide_t n);
        return ~n;
    endfunction

    function automatic logic [POP_W-1:0] mismatch_count(input logic [MAX_PAT_LEN-1:0] mm);
        logic [POP_W-1:0] n;
        n = {POP_W{1'b0}};
        for (int i = 0; i < MAX_PAT_LEN; i++) begin
            n = n + {{(POP_W-1){1'b0}}, mm[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gene_hamming_dist.sv
// Combinational per-channel compare: forward and reverse-complement Hamming
// distance of the window against one pattern, checked against its threshold.
module gene_hamming_dist
    import gene_pkg::*;
#(
    parameter int PAT_LEN = 8,
    parameter int DIST_W  = $clog2(PAT_LEN + 1)
) (
    input  nucleotide_t [PAT_LEN-1:0] i_win,
    input  nucleotide_t [PAT_LEN-1:0] i_pat,
    input  logic        [DIST_W-1:0]  i_thr,
    input  logic                      i_rc_en,
    output logic                      o_hit
);

    logic [MAX_PAT_LEN-1:0] w_mm_f;
    logic [MAX_PAT_LEN-1:0] w_mm_r;
    logic [POP_W-1:0]       w_dist_f;
    logic [POP_W-1:0]       w_dist_r;
    logic [POP_W-1:0]       w_thr;

    // Per-position mismatch flags; the reverse compare walks the pattern backwards.
    always_comb begin
        w_mm_f = {MAX_PAT_LEN{1'b0}};
        w_mm_r = {MAX_PAT_LEN{1'b0}};
        for (int i = 0; i < PAT_LEN; i++) begin
            w_mm_f[i] = (i_win[i] != i_pat[i]);
            w_mm_r[i] = (i_win[i] != complement(i_pat[PAT_LEN-1-i]));
        end
    end

    assign w_dist_f = mismatch_count(w_mm_f);
    assign w_dist_r = mismatch_count(w_mm_r);
    assign w_thr    = POP_W'(i_thr);
    assign o_hit    = (w_dist_f <= w_thr) | (i_rc_en & (w_dist_r <= w_thr));

endmodule

// File: rtl/gene_matcher_multi.sv
// Streaming DNA motif matcher: one sliding window compared against NUM_PAT
// loadable patterns, each with its own threshold and saturating hit counter.
module gene_matcher_multi
    import gene_pkg::*;
#(
    parameter  int PAT_LEN = 8,
    parameter  int NUM_PAT = 4,
    parameter  int CNT_W   = 8,
    localparam int DIST_W  = $clog2(PAT_LEN + 1),
    localparam int SEL_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         sym_in,
    input  logic               sym_valid,
    input  logic               clear,
    input  logic               rc_en,
    input  logic               cfg_we,
    input  logic               cfg_thr_we,
    input  logic [SEL_W-1:0]   cfg_chan,
    input  logic [1:0]         cfg_sym,
    input  logic [DIST_W-1:0]  cfg_thr,
    input  logic [SEL_W-1:0]   cnt_sel,
    output logic [NUM_PAT-1:0] match,
    output logic               match_any,
    output logic [CNT_W-1:0]   cnt_out
);

    nucleotide_t [PAT_LEN-1:0] r_win;
    logic        [DIST_W-1:0]  r_fill;
    logic                      r_pend;
    nucleotide_t [PAT_LEN-1:0] r_pat [NUM_PAT];
    logic        [DIST_W-1:0]  r_thr [NUM_PAT];
    logic        [CNT_W-1:0]   r_cnt [NUM_PAT];

    logic [NUM_PAT-1:0] w_hit;
    logic [NUM_PAT-1:0] w_fire;
    logic               w_full;

    assign w_full = (r_fill == DIST_W'(PAT_LEN));

    // Pattern and threshold storage; clear leaves configuration untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_PAT; c++) begin
                r_pat[c] <= {PAT_LEN{NT_A}};
                r_thr[c] <= {DIST_W{1'b0}};
            end
        end else begin
            for (int c = 0; c < NUM_PAT; c++) begin
                if (cfg_we && (cfg_chan == SEL_W'(c))) begin
                    r_pat[c] <= {r_pat[c][PAT_LEN-2:0], cfg_sym};
                end
                if (cfg_thr_we && (cfg_chan == SEL_W'(c))) begin
                    r_thr[c] <= cfg_thr;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_PAT; c++) begin : g_chan
        gene_hamming_dist #(
            .PAT_LEN (PAT_LEN),
            .DIST_W  (DIST_W)
        ) u_dist (
            .i_win   (r_win),
            .i_pat   (r_pat[c]),
            .i_thr   (r_thr[c]),
            .i_rc_en (rc_en),
            .o_hit   (w_hit[c])
        );
    end

    // A compare only fires one edge after a symbol was actually accepted.
    assign w_fire = w_hit & {NUM_PAT{w_full & r_pend}};

    // Window, fill level, match pulses and hit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win     <= {PAT_LEN{NT_A}};
            r_fill    <= {DIST_W{1'b0}};
            r_pend    <= 1'b0;
            match     <= {NUM_PAT{1'b0}};
            match_any <= 1'b0;
            for (int c = 0; c < NUM_PAT; c++) begin
                r_cnt[c] <= {CNT_W{1'b0}};
            end
        end else if (clear) begin
            r_fill    <= {DIST_W{1'b0}};
            r_pend    <= 1'b0;
            match     <= {NUM_PAT{1'b0}};
            match_any <= 1'b0;
            for (int c = 0; c < NUM_PAT; c++) begin
                r_cnt[c] <= {CNT_W{1'b0}};
            end
        end else begin
            if (sym_valid) begin
                r_win <= {r_win[PAT_LEN-2:0], sym_in};
                if (!w_full) begin
                    r_fill <= r_fill + DIST_W'(1);
                end
            end
            r_pend    <= sym_valid;
            match     <= w_fire;
            match_any <= |w_fire;
            for (int c = 0; c < NUM_PAT; c++) begin
                if (w_fire[c] && (r_cnt[c] != {CNT_W{1'b1}})) begin
                    r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    // Counter readback; an out-of-range select reads zero.
    always_comb begin
        cnt_out = {CNT_W{1'b0}};
        for (int c = 0; c < NUM_PAT; c++) begin
            cnt_out = (cnt_sel == SEL_W'(c)) ? r_cnt[c] : cnt_out;
        end
    end

endmodule
